// File: rtl/kp_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package kp_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // True when exactly one active-low column line is pulled low.
  function automatic logic one_low(input logic [COLS-1:0] col_n);
    logic [COLS-1:0] act;
    act = ~col_n;
    return (act != '0) && ((act & (act - (COLS)'(1))) == '0);
  endfunction

  // Bit position of the lowest low column line (only meaningful when one_low()).
  function automatic logic [1:0] col_index(input logic [COLS-1:0] col_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_n[c]) idx = 2'(c);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV cycles.
// Latency: tick is high in the cycle the count equals SCAN_DIV-1.
// Backpressure: none; the tick cannot be stalled.
module scan_tick_gen #(
  parameter int SCAN_DIV = 131072
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up and wrap after the last value of the scan period.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Divider register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, key-code output and an 8-digit history shift register.
// Latency: press accepted after DEBOUNCE_CNT stable ticks; KEY_VALID/KEY_CODE/Data update together, registered.
// Backpressure: none; KEY_VALID is a single-cycle pulse the consumer must capture.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV     = 131072,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic [ROWS-1:0] row_o,
  input  logic [COLS-1:0] col_i,
  output logic            key_valid_o,
  output key_code_t       key_code_o,
  output logic            key_held_o,
  output logic [31:0]     data_o
);

  // One spare count bit so the increment never wraps even for tiny DEBOUNCE_CNT.
  localparam int CW = $clog2(DEBOUNCE_CNT + 2);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT);

  logic            tick;
  logic [COLS-1:0] col_s1_q, col_s2_q;
  kp_state_e       state_q, state_d;
  logic [1:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [COLS-1:0] pat_q, pat_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  key_code_t       code_q, code_d;
  logic [31:0]     data_q, data_d;
  logic            col_idle;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .tick_o  (tick)
  );

  // Two-flop synchronizer for the asynchronous column inputs; idles high like the pull-ups.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= col_i;
      col_s2_q <= col_s1_q;
    end
  end

  assign col_idle = (col_s2_q == '1);
  assign cnt_inc  = cnt_q + CW'(1);

  // Scan/debounce state machine; every transition waits for a scan tick.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    valid_d = 1'b0;
    held_d  = held_q;
    code_d  = code_q;
    data_d  = data_q;
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (!col_idle && one_low(col_s2_q)) begin
            pat_d   = col_s2_q;
            cnt_d   = CW'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            // Idle row or a ghost/multi-key pattern: move on to the next row.
            r_d = r_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s2_q == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_MAX) begin
              valid_d = 1'b1;
              held_d  = 1'b1;
              code_d  = {r_q, col_index(pat_q)};
              data_d  = {data_q[27:0], r_q, col_index(pat_q)};
              state_d = ST_HELD;
            end
          end else begin
            state_d = ST_SCAN;
            r_d     = r_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (col_idle) begin
            cnt_d   = CW'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (col_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_MAX) begin
              held_d  = 1'b0;
              state_d = ST_SCAN;
              r_d     = r_q + 2'd1;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
      endcase
    end
  end

  // State, row index, debounce bookkeeping and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_SCAN;
      r_q     <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= '1;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      code_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  assign row_o       = ~(4'b0001 << r_q);
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign key_held_o  = held_q;
  assign data_o      = data_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner with a behavioural keypad matrix model.
// Latency: expected pulses are queued at stimulus time and popped by an independent monitor.
// Backpressure: none; every KEY_VALID pulse must match the head of the queue.
module tb_keypad_scanner;
  import kp_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  key_code_t   key_code;
  logic        key_held;
  logic [31:0] data;
  logic [15:0] keys_down = '0;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [31:0] model_data = '0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .row_o       (row),
    .col_i       (col),
    .key_valid_o (key_valid),
    .key_code_o  (key_code),
    .key_held_o  (key_held),
    .data_o      (data)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys_down[r*4+c]) col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted key must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual code=%0h data=%0h required=no pulse", key_code, data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_code", 32'(key_code), 32'(e.code));
        check("pulse_data", data, e.data);
        check("pulse_held", 32'(key_held), 32'd1);
      end
    end
  end

  // Row monitor: one row low, rows advance by one position, never while a key is held.
  logic [3:0] prev_row = 4'hE;
  logic       prev_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      check("row_one_low", 32'($countones(~row)), 32'd1);
      if (prev_ok && row != prev_row) begin
        check("row_rotate", 32'(row), 32'({prev_row[2:0], prev_row[3]}));
        check("row_frozen_when_held", 32'(key_held), 32'd0);
      end
      prev_row = row;
      prev_ok  = 1'b1;
    end
  end

  // Queue the expected acceptance and hold the key down; caller releases.
  task automatic press_long(input int r, input int c, input int hold);
    exp_t e;
    model_data = {model_data[27:0], 4'(r*4 + c)};
    e.code = 4'(r*4 + c);
    e.data = model_data;
    exp_q.push_back(e);
    keys_down[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    check("pulse_within_latency", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Global time limit so the run always ends.
  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int changes;
    int cur;
    int kr;
    logic [3:0] target;
    logic [3:0] last_row;

    // Reset values.
    rst_n = 1'b0;
    gap(3);
    check("rst_row", 32'(row), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_data", data, 32'd0);
    rst_n = 1'b1;
    gap(10);

    // Stable press of row 2 / col 1.
    press_long(2, 1, 60);
    check("k9_code", 32'(key_code), 32'h9);
    check("k9_data", data, 32'h00000009);
    check("k9_held", 32'(key_held), 32'd1);
    keys_down = '0;
    gap(30);
    check("k9_released", 32'(key_held), 32'd0);

    // One-tick bounce on row 0 / col 3: no acceptance.
    keys_down[0*4+3] = 1'b1;
    gap(SCAN_DIV);
    keys_down = '0;
    gap(30);
    check("bounce_data", data, 32'h00000009);

    // Two keys in row 1 at once: ghost pattern, scanning keeps rotating.
    keys_down[1*4+0] = 1'b1;
    keys_down[1*4+2] = 1'b1;
    changes = 0;
    last_row = row;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (row != last_row) changes++;
      last_row = row;
    end
    keys_down = '0;
    check("ghost_rotates", 32'(changes >= 16), 32'd1);
    check("ghost_held", 32'(key_held), 32'd0);
    gap(20);

    // Keys with codes 1..9 in order.
    for (int k = 1; k <= 9; k++) begin
      press_long(k / 4, k % 4, 40);
      keys_down = '0;
      gap(24);
    end
    check("seq_data", data, 32'h23456789);

    // Long hold: one pulse, release debounced about two ticks later.
    press_long(3, 2, 200);
    check("long_held", 32'(key_held), 32'd1);
    keys_down = '0;
    n = 0;
    while (key_held && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held_fall_not_early", 32'(n >= 6), 32'd1);
    check("held_fall_not_late", 32'(n <= 11), 32'd1);
    gap(20);

    // Randomized mix of real presses, bounces and ghost patterns.
    for (int i = 0; i < 24; i++) begin
      int kind, rr, kc, kc2;
      kind = $urandom_range(0, 3);
      rr   = $urandom_range(0, 3);
      kc   = $urandom_range(0, 3);
      if (kind <= 1) begin
        press_long(rr, kc, $urandom_range(32, 70));
        keys_down = '0;
      end else if (kind == 2) begin
        keys_down[rr*4+kc] = 1'b1;
        gap(SCAN_DIV);
        keys_down = '0;
      end else begin
        kc2 = (kc + 1 + $urandom_range(0, 2)) % 4;
        keys_down[rr*4+kc]  = 1'b1;
        keys_down[rr*4+kc2] = 1'b1;
        gap($urandom_range(30, 60));
        keys_down = '0;
      end
      gap($urandom_range(20, 40));
    end
    check("random_data", data, model_data);

    // Reset while a key is being debounced: abandoned with no pulse.
    cur = 0;
    for (int b = 0; b < 4; b++) if (!row[b]) cur = b;
    kr = (cur + 2) % 4;
    target = ~(4'b0001 << kr);
    keys_down[kr*4+1] = 1'b1;
    n = 0;
    while (row != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("dbrst_row_reached", 32'(row), 32'(target));
    gap(5);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("dbrst_row", 32'(row), 32'hE);
    check("dbrst_valid", 32'(key_valid), 32'd0);
    check("dbrst_held", 32'(key_held), 32'd0);
    check("dbrst_code", 32'(key_code), 32'd0);
    check("dbrst_data", data, 32'd0);
    keys_down = '0;
    gap(3);
    rst_n = 1'b1;
    model_data = '0;
    @(negedge clk);
    check("dbrst_restart_row", 32'(row), 32'hE);
    gap(20);
    check("dbrst_no_pending", 32'(exp_q.size()), 32'd0);

    // Fresh history after reset.
    press_long(0, 2, 40);
    keys_down = '0;
    gap(24);
    check("post_rst_data", data, 32'h00000002);

    gap(20);
    check("all_pulses_seen", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
